// File: rtl/wb_regfile_if.sv
// MEM/WB consumer bus: writeback controls and data in, decode read ports and retirement trace out.
interface wb_regfile_if #(
  parameter int DATA_W = 64
);
  logic              REGWRITE_IN;
  logic              MEM2REG_IN;
  logic [DATA_W-1:0] MEM_DATA;
  logic [DATA_W-1:0] ALU_VAL;
  logic [4:0]        REG_DESTINATION;
  logic [31:0]       INSTR_IN;
  logic [31:0]       PC_IN;
  logic [4:0]        READ_REG1;
  logic [4:0]        READ_REG2;
  logic [DATA_W-1:0] READ_DATA1;
  logic [DATA_W-1:0] READ_DATA2;
  logic [DATA_W-1:0] WB_DATA;
  logic              WB_WE;
  logic [31:0]       RETIRE_COUNT;
  logic [31:0]       LAST_PC;
  logic [31:0]       LAST_INSTR;

  modport master (
    output REGWRITE_IN, MEM2REG_IN, MEM_DATA, ALU_VAL, REG_DESTINATION,
           INSTR_IN, PC_IN, READ_REG1, READ_REG2,
    input  READ_DATA1, READ_DATA2, WB_DATA, WB_WE,
           RETIRE_COUNT, LAST_PC, LAST_INSTR
  );

  modport slave (
    input  REGWRITE_IN, MEM2REG_IN, MEM_DATA, ALU_VAL, REG_DESTINATION,
           INSTR_IN, PC_IN, READ_REG1, READ_REG2,
    output READ_DATA1, READ_DATA2, WB_DATA, WB_WE,
           RETIRE_COUNT, LAST_PC, LAST_INSTR
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux + 32-entry register file; reads combinational with write-through, writes and retirement on the WB edge.
// No backpressure: one instruction accepted every cycle.
module wb_regfile #(
  parameter int DATA_W    = 64,
  parameter int ZERO_REG  = 31,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic         CLK,
  input logic         RESET,
  wb_regfile_if.slave bus
);
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [31:0]       retire_count_q;
  logic [31:0]       last_pc_q;
  logic [31:0]       last_instr_q;

  assign wb_data = bus.MEM2REG_IN ? bus.MEM_DATA : bus.ALU_VAL;
  assign wb_we   = bus.REGWRITE_IN && (bus.REG_DESTINATION != ZERO_IDX);

  // The XZR entry is never written, so it stays constant zero and folds away.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[bus.REG_DESTINATION] <= wb_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      retire_count_q <= '0;
      last_pc_q      <= '0;
      last_instr_q   <= '0;
    end else if (bus.INSTR_IN != 32'h0) begin
      retire_count_q <= retire_count_q + 32'd1;
      last_pc_q      <= bus.PC_IN;
      last_instr_q   <= bus.INSTR_IN;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic [4:0]        dest,
    input logic              we,
    input logic [DATA_W-1:0] wdat,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (addr == ZERO_IDX) v = '0;
    else if (BYPASS_EN && we && (addr == dest)) v = wdat;
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(bus.READ_REG1, bus.REG_DESTINATION, wb_we, wb_data, regs[bus.READ_REG1]);
    rd2 = read_port(bus.READ_REG2, bus.REG_DESTINATION, wb_we, wb_data, regs[bus.READ_REG2]);
  end

  assign bus.READ_DATA1   = rd1;
  assign bus.READ_DATA2   = rd2;
  assign bus.WB_DATA      = wb_data;
  assign bus.WB_WE        = wb_we;
  assign bus.RETIRE_COUNT = retire_count_q;
  assign bus.LAST_PC      = last_pc_q;
  assign bus.LAST_INSTR   = last_instr_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Drives a bypassing and a non-bypassing wb_regfile with identical stimulus and checks both.
module tb_wb_regfile;
  logic        CLK;
  logic        RESET;
  logic        rw, m2r;
  logic [63:0] mem, alu;
  logic [4:0]  dest, rr1, rr2;
  logic [31:0] instr, pc;

  int total = 0;
  int bad   = 0;

  wb_regfile_if #(.DATA_W(64)) bus_a ();
  wb_regfile_if #(.DATA_W(64)) bus_b ();

  assign bus_a.REGWRITE_IN = rw;     assign bus_b.REGWRITE_IN = rw;
  assign bus_a.MEM2REG_IN  = m2r;    assign bus_b.MEM2REG_IN  = m2r;
  assign bus_a.MEM_DATA    = mem;    assign bus_b.MEM_DATA    = mem;
  assign bus_a.ALU_VAL     = alu;    assign bus_b.ALU_VAL     = alu;
  assign bus_a.REG_DESTINATION = dest; assign bus_b.REG_DESTINATION = dest;
  assign bus_a.INSTR_IN    = instr;  assign bus_b.INSTR_IN    = instr;
  assign bus_a.PC_IN       = pc;     assign bus_b.PC_IN       = pc;
  assign bus_a.READ_REG1   = rr1;    assign bus_b.READ_REG1   = rr1;
  assign bus_a.READ_REG2   = rr2;    assign bus_b.READ_REG2   = rr2;

  wb_regfile #(.DATA_W(64), .ZERO_REG(31), .BYPASS_EN(1'b1)) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
  wb_regfile #(.DATA_W(64), .ZERO_REG(31), .BYPASS_EN(1'b0)) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: architectural state as plain arrays and counters.
  logic [63:0] m_regs [32];
  logic [31:0] m_cnt, m_pc, m_instr;

  function automatic logic [63:0] m_wb();
    return m2r ? mem : alu;
  endfunction

  function automatic logic m_we();
    return rw && (dest != 5'd31);
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a, input logic byp);
    if (a == 5'd31) return 64'h0;
    if (byp && m_we() && a == dest) return m_wb();
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
    m_cnt = 0; m_pc = 0; m_instr = 0;
  endtask

  task automatic m_commit();
    if (m_we()) m_regs[dest] = m_wb();
    if (instr != 32'h0) begin
      m_cnt   = m_cnt + 32'd1;
      m_pc    = pc;
      m_instr = instr;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (!RESET) m_commit();
    @(negedge CLK);
  endtask

  task automatic idle();
    rw = 0; m2r = 0; mem = 0; alu = 0; dest = 0; instr = 0; pc = 0;
  endtask

  task automatic check_retire();
    check("cnt_a",   64'(bus_a.RETIRE_COUNT), 64'(m_cnt));
    check("pc_a",    64'(bus_a.LAST_PC),      64'(m_pc));
    check("instr_a", 64'(bus_a.LAST_INSTR),   64'(m_instr));
    check("cnt_b",   64'(bus_b.RETIRE_COUNT), 64'(m_cnt));
  endtask

  typedef struct {
    logic        rw, m2r;
    logic [63:0] mem, alu;
    logic [4:0]  dest, rr1, rr2;
    logic [31:0] instr, pc;
    logic [63:0] e_wb;
    logic        e_we;
    logic [63:0] e_a1, e_a2, e_b1, e_b2;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h5, 5'd3, 5'd3, 5'd4, 32'h11, 32'h0,
                64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'h0, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h5, 5'd4, 5'd3, 5'd4, 32'h12, 32'h4,
                64'h5, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h5, 64'hDEAD_BEEF_0000_0001, 64'h0};
    vecs[2] = '{1'b0, 1'b0, 64'h0, 64'h9, 5'd3, 5'd3, 5'd4, 32'h0, 32'h8,
                64'h9, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h5, 64'hDEAD_BEEF_0000_0001, 64'h5};
    vecs[3] = '{1'b1, 1'b0, 64'h0, 64'hFFFF, 5'd31, 5'd31, 5'd3, 32'h13, 32'hC,
                64'hFFFF, 1'b0, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'hDEAD_BEEF_0000_0001};
    vecs[4] = '{1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd31, 5'd4, 32'h0, 32'h10,
                64'h0, 1'b0, 64'h0, 64'h5, 64'h0, 64'h5};

    RESET = 1'b1; idle(); rr1 = 0; rr2 = 0;
    m_clear();
    #2;
    check("rst_rd1_a", bus_a.READ_DATA1, 64'h0);
    check("rst_cnt_a", 64'(bus_a.RETIRE_COUNT), 64'h0);
    check("rst_pc_a",  64'(bus_a.LAST_PC), 64'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // Table: mux select, write, bypass vs. stored read, XZR discard.
    for (int v = 0; v < 5; v++) begin
      rw = vecs[v].rw; m2r = vecs[v].m2r; mem = vecs[v].mem; alu = vecs[v].alu;
      dest = vecs[v].dest; rr1 = vecs[v].rr1; rr2 = vecs[v].rr2;
      instr = vecs[v].instr; pc = vecs[v].pc;
      #1;
      check($sformatf("v%0d_wb", v),  bus_a.WB_DATA, vecs[v].e_wb);
      check($sformatf("v%0d_we", v),  64'(bus_a.WB_WE), 64'(vecs[v].e_we));
      check($sformatf("v%0d_a1", v),  bus_a.READ_DATA1, vecs[v].e_a1);
      check($sformatf("v%0d_a2", v),  bus_a.READ_DATA2, vecs[v].e_a2);
      check($sformatf("v%0d_b1", v),  bus_b.READ_DATA1, vecs[v].e_b1);
      check($sformatf("v%0d_b2", v),  bus_b.READ_DATA2, vecs[v].e_b2);
      step();
    end
    check_retire();

    // Bypass on both ports in the write cycle.
    idle(); rw = 1; alu = 64'h11; dest = 5'd7;
    step();
    alu = 64'h22; rr1 = 5'd7; rr2 = 5'd7;
    #1;
    check("byp_a1", bus_a.READ_DATA1, 64'h22);
    check("byp_a2", bus_a.READ_DATA2, 64'h22);
    check("nobyp_b1", bus_b.READ_DATA1, 64'h11);
    check("nobyp_b2", bus_b.READ_DATA2, 64'h11);
    step();
    idle();
    #1;
    check("post_b1", bus_b.READ_DATA1, 64'h22);
    check("post_a2", bus_a.READ_DATA2, 64'h22);

    // Mid-cycle asynchronous reset with nonzero state.
    #2;
    RESET = 1'b1;
    #1;
    check("arst_rd1_a", bus_a.READ_DATA1, 64'h0);
    check("arst_rd2_b", bus_b.READ_DATA2, 64'h0);
    check("arst_cnt_a", 64'(bus_a.RETIRE_COUNT), 64'h0);
    check("arst_pc_a",  64'(bus_a.LAST_PC), 64'h0);
    check("arst_ins_a", 64'(bus_a.LAST_INSTR), 64'h0);
    m_clear();
    @(negedge CLK);
    RESET = 1'b0;

    // Retirement: three instructions, a bubble, one more.
    for (int k = 0; k < 3; k++) begin
      instr = 32'h100 + 32'(k); pc = 32'h10 + 32'(4 * k);
      step();
    end
    instr = 32'h0; pc = 32'h99;
    step();
    check("bub_pc",  64'(bus_a.LAST_PC), 64'h18);
    check("bub_ins", 64'(bus_a.LAST_INSTR), 64'h102);
    check("bub_cnt", 64'(bus_a.RETIRE_COUNT), 64'h3);
    instr = 32'h8B02_0020; pc = 32'h40;
    step();
    check("ret_cnt", 64'(bus_a.RETIRE_COUNT), 64'h4);
    check("ret_pc",  64'(bus_a.LAST_PC), 64'h40);
    check("ret_ins", 64'(bus_a.LAST_INSTR), 64'h8B02_0020);
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rw    = ($urandom_range(0, 3) != 0);
      m2r   = $urandom_range(0, 1) == 1;
      mem   = {$urandom, $urandom};
      alu   = {$urandom, $urandom};
      dest  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      rr1   = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, 31));
      rr2   = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, 31));
      instr = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      pc    = $urandom;
      #1;
      check("rnd_wb",  bus_a.WB_DATA, m_wb());
      check("rnd_we",  64'(bus_a.WB_WE), 64'(m_we()));
      check("rnd_a1",  bus_a.READ_DATA1, m_read(rr1, 1'b1));
      check("rnd_a2",  bus_a.READ_DATA2, m_read(rr2, 1'b1));
      check("rnd_b1",  bus_b.READ_DATA1, m_read(rr1, 1'b0));
      check("rnd_b2",  bus_b.READ_DATA2, m_read(rr2, 1'b0));
      step();
      check_retire();
    end

    // Counter wrap via backdoor on the bypassing instance.
    idle();
    force dut_a.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut_a.retire_count_q;
    #1;
    check("wrap_pre", 64'(bus_a.RETIRE_COUNT), 64'hFFFF_FFFF);
    instr = 32'h1234; pc = 32'h80;
    step();
    check("wrap_cnt", 64'(bus_a.RETIRE_COUNT), 64'h0);
    check("wrap_pc",  64'(bus_a.LAST_PC), 64'h80);

    // Reset coinciding with a write edge.
    idle(); rw = 1; alu = 64'h55; dest = 5'd5;
    step();
    alu = 64'h77;
    #4;
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    idle(); rr1 = 5'd5; rr2 = 5'd5;
    #1;
    check("race_a1", bus_a.READ_DATA1, 64'h0);
    check("race_b2", bus_b.READ_DATA2, 64'h0);
    check("race_cnt", 64'(bus_a.RETIRE_COUNT), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
